// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: Moore FSM that sequences fetch,
// decode, execute, memory and write-back, with a memory-wait timeout.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   run               allows a new instruction to start (sampled in FETCH)
//   opcode, funct     instruction fields from the instruction register
//   zero              ALU zero flag (qualifies the branch PC write)
//   mem_ready         memory completes the current access this cycle
//   pc_write .. pc_src  datapath control strobes and mux selects
//   state             current state encoding (FETCH = 0 .. ERR = 12)
//   instr_done        pulse in the last cycle of each instruction
//   err               sticky error: 01 illegal instruction, 10 timeout
module multicycle_control #(
    parameter int WAIT_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic [1:0] pc_src,
    output logic [3:0] state,
    output logic       instr_done,
    output logic [1:0] err
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        EXEC_I = 4'd3,
        ADDR   = 4'd4,
        MEM_RD = 4'd5,
        MEM_WR = 4'd6,
        WB_R   = 4'd7,
        WB_I   = 4'd8,
        WB_MEM = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11,
        ERR    = 4'd12
    } state_t;

    // Counter holds completed wait cycles; the timeout fires on the
    // edge that would complete wait cycle number WAIT_LIMIT.
    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CW-1:0] WLAST = CW'(WAIT_LIMIT - 1);

    state_t        cur;
    logic [CW-1:0] wcnt;
    logic          r_ok;
    logic          tmo;

    assign r_ok = (funct == 6'h20) || (funct == 6'h21) ||
                  (funct == 6'h22) || (funct == 6'h24);
    assign tmo   = !mem_ready && (wcnt == WLAST);
    assign state = cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur  <= FETCH;
            err  <= 2'b00;
            wcnt <= '0;
        end else begin
            // Any cycle that is not a continuing wait clears the count.
            wcnt <= '0;
            case (cur)
                FETCH: begin
                    if (run) begin
                        if (mem_ready) begin
                            cur <= DECODE;
                        end else if (tmo) begin
                            cur <= ERR;
                            err <= 2'b10;
                        end else begin
                            wcnt <= wcnt + CW'(1);
                        end
                    end
                end
                DECODE: begin
                    unique case (1'b1)
                        (opcode == 6'h00) && r_ok:
                            cur <= EXEC_R;
                        opcode == 6'h08:
                            cur <= EXEC_I;
                        (opcode == 6'h23) || (opcode == 6'h2B):
                            cur <= ADDR;
                        opcode == 6'h04:
                            cur <= BRANCH;
                        opcode == 6'h02:
                            cur <= JUMP;
                        default: begin
                            cur <= ERR;
                            err <= 2'b01;
                        end
                    endcase
                end
                EXEC_R: cur <= WB_R;
                EXEC_I: cur <= WB_I;
                ADDR:   cur <= (opcode == 6'h2B) ? MEM_WR : MEM_RD;
                MEM_RD: begin
                    if (mem_ready) begin
                        cur <= WB_MEM;
                    end else if (tmo) begin
                        cur <= ERR;
                        err <= 2'b10;
                    end else begin
                        wcnt <= wcnt + CW'(1);
                    end
                end
                MEM_WR: begin
                    if (mem_ready) begin
                        cur <= FETCH;
                    end else if (tmo) begin
                        cur <= ERR;
                        err <= 2'b10;
                    end else begin
                        wcnt <= wcnt + CW'(1);
                    end
                end
                WB_R, WB_I, WB_MEM, BRANCH, JUMP: cur <= FETCH;
                ERR:     cur <= ERR;
                default: cur <= FETCH;
            endcase
        end
    end

    // Outputs decode from state; rst gates them so they drop at once.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 4'b0000;
        pc_src     = 2'b00;
        instr_done = 1'b0;
        if (!rst) begin
            case (cur)
                FETCH: begin
                    if (run) begin
                        mem_read  = 1'b1;
                        alu_src_b = 2'b01;
                        ir_write  = mem_ready;
                        pc_write  = mem_ready;
                    end
                end
                DECODE: alu_src_b = 2'b11;
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    case (funct)
                        6'h22:   alu_op = 4'b0001;
                        6'h24:   alu_op = 4'b0010;
                        default: alu_op = 4'b0000;
                    endcase
                end
                EXEC_I, ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                MEM_WR: begin
                    mem_write  = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem_ready;
                end
                WB_R: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                WB_I: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = 4'b0001;
                    pc_src     = 2'b01;
                    pc_write   = zero;
                    instr_done = 1'b1;
                end
                JUMP: begin
                    pc_src     = 2'b10;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle vector table through a
// scoreboard queue, plus hand sequences for timeout and async reset.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst, run, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       pc_write, ir_write, iord, mem_read, mem_write;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src, err;
    logic [3:0] alu_op, state;
    logic       instr_done;

    always #5 clk = ~clk;

    multicycle_control #(.WAIT_LIMIT(8)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .state(state), .instr_done(instr_done), .err(err)
    );

    typedef struct packed {
        logic       pcw, irw, iord, mr, mw, rw, rd, m2r, asa;
        logic [1:0] asb;
        logic [3:0] aop;
        logic [1:0] psrc;
        logic       done;
    } ctrl_t;

    typedef struct packed {
        logic       rst, run;
        logic [5:0] op, fn;
        logic       z, rdy;
        logic [3:0] st;
        ctrl_t      c;
        logic [1:0] e;
    } vec_t;

    typedef struct packed {
        logic [3:0] st;
        ctrl_t      c;
        logic [1:0] e;
    } exp_t;

    localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_XR = 4'd2,
        S_XI = 4'd3, S_AD = 4'd4, S_MR = 4'd5, S_MW = 4'd6,
        S_WR = 4'd7, S_WI = 4'd8, S_WM = 4'd9, S_BR = 4'd10,
        S_J = 4'd11, S_E = 4'd12;

    localparam ctrl_t K0 = '0;
    localparam ctrl_t K_F = '{pcw:1'b1, irw:1'b1, mr:1'b1,
                              asb:2'b01, default:'0};
    localparam ctrl_t K_FW = '{mr:1'b1, asb:2'b01, default:'0};
    localparam ctrl_t K_D = '{asb:2'b11, default:'0};
    localparam ctrl_t K_XA = '{asa:1'b1, default:'0};
    localparam ctrl_t K_XS = '{asa:1'b1, aop:4'b0001, default:'0};
    localparam ctrl_t K_XN = '{asa:1'b1, aop:4'b0010, default:'0};
    localparam ctrl_t K_IM = '{asa:1'b1, asb:2'b10, default:'0};
    localparam ctrl_t K_WR = '{rw:1'b1, rd:1'b1, done:1'b1,
                               default:'0};
    localparam ctrl_t K_WI = '{rw:1'b1, done:1'b1, default:'0};
    localparam ctrl_t K_MR = '{mr:1'b1, iord:1'b1, default:'0};
    localparam ctrl_t K_WM = '{rw:1'b1, m2r:1'b1, done:1'b1,
                               default:'0};
    localparam ctrl_t K_MWW = '{mw:1'b1, iord:1'b1, default:'0};
    localparam ctrl_t K_MWD = '{mw:1'b1, iord:1'b1, done:1'b1,
                                default:'0};
    localparam ctrl_t K_BT = '{asa:1'b1, aop:4'b0001, psrc:2'b01,
                               pcw:1'b1, done:1'b1, default:'0};
    localparam ctrl_t K_BN = '{asa:1'b1, aop:4'b0001, psrc:2'b01,
                               done:1'b1, default:'0};
    localparam ctrl_t K_J = '{psrc:2'b10, pcw:1'b1, done:1'b1,
                              default:'0};

    ctrl_t act;
    assign act = {pc_write, ir_write, iord, mem_read, mem_write,
                  reg_write, reg_dst, mem_to_reg, alu_src_a,
                  alu_src_b, alu_op, pc_src, instr_done};

    vec_t       tbl[$];
    exp_t       exp_q[$];
    logic [5:0] c_op, c_fn;
    logic       c_z;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic ins(input logic [5:0] op, input logic [5:0] fn,
                       input logic z);
        c_op = op;
        c_fn = fn;
        c_z  = z;
    endtask

    task automatic r(input logic ru, input logic rdy,
                     input logic [3:0] st, input ctrl_t c,
                     input logic [1:0] e);
        tbl.push_back('{rst:1'b0, run:ru, op:c_op, fn:c_fn, z:c_z,
                        rdy:rdy, st:st, c:c, e:e});
    endtask

    task automatic f(input logic [3:0] st, input ctrl_t c);
        r(1'b1, 1'b1, st, c, 2'b00);
    endtask

    task automatic rr();
        tbl.push_back('{rst:1'b1, run:1'b1, op:c_op, fn:c_fn, z:c_z,
                        rdy:1'b1, st:S_F, c:K0, e:2'b00});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        opcode = 6'h00; funct = 6'h00;

        ins(6'h00, 6'h00, 1'b0);
        rr(); rr();
        ins(6'h00, 6'h20, 1'b0);
        f(S_F, K_F); f(S_D, K_D); f(S_XR, K_XA); f(S_WR, K_WR);
        ins(6'h00, 6'h21, 1'b0);
        f(S_F, K_F); f(S_D, K_D); f(S_XR, K_XA); f(S_WR, K_WR);
        ins(6'h00, 6'h22, 1'b0);
        f(S_F, K_F); f(S_D, K_D); f(S_XR, K_XS); f(S_WR, K_WR);
        ins(6'h00, 6'h24, 1'b0);
        f(S_F, K_F); f(S_D, K_D); f(S_XR, K_XN); f(S_WR, K_WR);
        ins(6'h08, 6'h00, 1'b0);
        f(S_F, K_F); f(S_D, K_D); f(S_XI, K_IM); f(S_WI, K_WI);
        ins(6'h23, 6'h00, 1'b0);
        f(S_F, K_F); f(S_D, K_D); f(S_AD, K_IM);
        for (int i = 0; i < 3; i++) r(1'b1, 1'b0, S_MR, K_MR, 2'b00);
        f(S_MR, K_MR); f(S_WM, K_WM);
        ins(6'h2B, 6'h00, 1'b0);
        f(S_F, K_F); f(S_D, K_D); f(S_AD, K_IM); f(S_MW, K_MWD);
        ins(6'h04, 6'h00, 1'b1);
        f(S_F, K_F); f(S_D, K_D); f(S_BR, K_BT);
        ins(6'h04, 6'h00, 1'b0);
        f(S_F, K_F); f(S_D, K_D); f(S_BR, K_BN);
        ins(6'h02, 6'h00, 1'b0);
        f(S_F, K_F); f(S_D, K_D); f(S_J, K_J);
        ins(6'h08, 6'h00, 1'b0);
        r(1'b0, 1'b1, S_F, K0, 2'b00);
        r(1'b0, 1'b1, S_F, K0, 2'b00);
        f(S_F, K_F);
        r(1'b0, 1'b1, S_D, K_D, 2'b00);
        r(1'b0, 1'b1, S_XI, K_IM, 2'b00);
        r(1'b0, 1'b1, S_WI, K_WI, 2'b00);
        r(1'b0, 1'b1, S_F, K0, 2'b00);
        ins(6'h23, 6'h00, 1'b0);
        for (int i = 0; i < 5; i++) r(1'b1, 1'b0, S_F, K_FW, 2'b00);
        f(S_F, K_F); f(S_D, K_D); f(S_AD, K_IM);
        for (int i = 0; i < 5; i++) r(1'b1, 1'b0, S_MR, K_MR, 2'b00);
        f(S_MR, K_MR); f(S_WM, K_WM);
        ins(6'h2B, 6'h00, 1'b0);
        f(S_F, K_F); f(S_D, K_D); f(S_AD, K_IM);
        for (int i = 0; i < 7; i++) r(1'b1, 1'b0, S_MW, K_MWW, 2'b00);
        f(S_MW, K_MWD);
        ins(6'h3F, 6'h00, 1'b0);
        f(S_F, K_F); f(S_D, K_D);
        r(1'b1, 1'b1, S_E, K0, 2'b01);
        r(1'b1, 1'b1, S_E, K0, 2'b01);
        r(1'b1, 1'b0, S_E, K0, 2'b01);
        rr();
        ins(6'h00, 6'h25, 1'b0);
        f(S_F, K_F); f(S_D, K_D);
        r(1'b1, 1'b1, S_E, K0, 2'b01);
        r(1'b1, 1'b1, S_E, K0, 2'b01);
        rr();

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            exp_t x;
            rst       = tbl[i].rst;
            run       = tbl[i].run;
            opcode    = tbl[i].op;
            funct     = tbl[i].fn;
            zero      = tbl[i].z;
            mem_ready = tbl[i].rdy;
            exp_q.push_back('{st:tbl[i].st, c:tbl[i].c, e:tbl[i].e});
            @(negedge clk);
            x = exp_q.pop_front();
            chk($sformatf("vec[%0d]", i),
                32'({state, act, err}), 32'({x.st, x.c, x.e}));
            @(posedge clk);
            #1;
        end

        // fetch timeout: 8 wait cycles, no ir_write/pc_write
        run = 1'b1; mem_ready = 1'b0; opcode = 6'h08; funct = 6'h00;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("fetch_wait[%0d]", i),
                32'({state, ir_write, pc_write}), 32'({S_F, 2'b00}));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("fetch_tmo", 32'({state, err, mem_read}),
            32'({S_E, 2'b10, 1'b0}));
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("fetch_tmo_hold", 32'({state, err, ir_write}),
            32'({S_E, 2'b10, 1'b0}));

        // load timeout in MEM_RD: no reg_write
        opcode = 6'h23; mem_ready = 1'b1;
        do_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("rd_wait[%0d]", i),
                32'({state, mem_read, reg_write}),
                32'({S_MR, 2'b10}));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("rd_tmo", 32'({state, err, reg_write}),
            32'({S_E, 2'b10, 1'b0}));

        // async reset in a MEM_WR wait, then run=0 holds FETCH
        opcode = 6'h2B; mem_ready = 1'b1;
        do_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        chk("wr_wait", 32'({state, mem_write}), 32'({S_MW, 1'b1}));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", 32'({state, mem_write, err}),
            32'({S_F, 1'b0, 2'b00}));
        run = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("idle[%0d]", i),
                32'({state, mem_read, ir_write}), 32'({S_F, 2'b00}));
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: WAIT_LIMIT, default 8, consecutive memory wait cycles tolerated before a timeout error is flagged.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 run  input  1  permission to start a new instruction; sampled in FETCH only.
REQ-005 opcode  input  6  instruction[31:26] from the instruction register.
REQ-006 funct  input  6  instruction[5:0] from the instruction register.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  memory completes the current read/write this cycle.
REQ-009 pc_write  output  1  load PC.
REQ-010 ir_write  output  1  load instruction register.
REQ-011 iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-012 mem_read / mem_write  output  1 each  memory strobes.
REQ-013 reg_write  output  1  register file write enable.
REQ-014 reg_dst  output  1  write address: 0 = rt, 1 = rd.
REQ-015 mem_to_reg  output  1  write data: 0 = ALUOut, 1 = memory data register.
REQ-016 alu_src_a  output  1  0 = PC, 1 = rs.
REQ-017 alu_src_b  output  2  00 = rt, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
REQ-018 alu_op  output  4  0000 = add, 0001 = sub, 0010 = and.
REQ-019 pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], adr, 2'b00}.
REQ-020 state  output  4  current state encoding.
REQ-021 instr_done  output  1  one-cycle pulse in the final cycle of each instruction.
REQ-022 err  output  2  00 = none, 01 = illegal instruction, 10 = memory timeout; sticky.

Function
REQ-023 The block SHALL be a Moore FSM; all outputs except the conditional pc_write in BRANCH and the mem_ready-qualified strobes SHALL depend only on state; unlisted outputs SHALL be 0 in every state.
REQ-024 States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, ERR.
REQ-025 FETCH: if run=0, hold with all outputs 0; if run=1, assert mem_read, iord=0, alu_src_a=0, alu_src_b=01, alu_op=0000, pc_src=00; ir_write and pc_write asserted only in the cycle mem_ready=1, which advances to DECODE.
REQ-026 DECODE: alu_src_a=0, alu_src_b=11, alu_op=0000 (branch target precompute); next state by opcode: 0x00 with funct 0x20/0x21/0x22/0x24 -> EXEC_R, 0x08 -> EXEC_I, 0x23/0x2B -> ADDR, 0x04 -> BRANCH, 0x02 -> JUMP, anything else -> ERR with err=01.
REQ-027 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op 0000 for funct 0x20/0x21, 0001 for 0x22, 0010 for 0x24; -> WB_R.
REQ-028 WB_R: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; -> FETCH.
REQ-029 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=0000; -> WB_I; WB_I: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1; -> FETCH.
REQ-030 ADDR: alu_src_a=1, alu_src_b=10, alu_op=0000; -> MEM_RD for 0x23, MEM_WR for 0x2B.
REQ-031 MEM_RD: mem_read=1, iord=1; on mem_ready -> WB_MEM; WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1; -> FETCH.
REQ-032 MEM_WR: mem_write=1, iord=1; on mem_ready, instr_done=1 and -> FETCH.
REQ-033 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=0001, pc_src=01, pc_write=zero, instr_done=1; -> FETCH.
REQ-034 JUMP: pc_src=10, pc_write=1, instr_done=1; -> FETCH.
REQ-035 Cycle counts with mem_ready always 1: lw 5, sw/R-type/addi 4, beq/j 3.
REQ-036 A wait counter SHALL count consecutive cycles in FETCH (run=1), MEM_RD or MEM_WR with mem_ready=0, clear on mem_ready=1 or state exit, and on reaching WAIT_LIMIT move to ERR with err=10, without strobing ir_write, pc_write or reg_write.
REQ-037 ERR: all outputs 0 except state and err; held until rst.
REQ-038 run deasserted mid-instruction SHALL NOT affect the instruction in flight; it only stops the next FETCH.

Reset
REQ-039 rst=1 SHALL immediately force state=FETCH, err=00, wait counter=0, all other outputs 0, including mid-memory-wait or ERR; operation resumes on the first rising edge after rst falls.

Verification
REQ-040 run=1, mem_ready=1, add r3,r1,r2 (funct 0x20) -> FETCH,DECODE,EXEC_R,WB_R; reg_write=1, reg_dst=1 only in WB_R; instr_done in cycle 4.
REQ-041 lw with mem_ready low 3 cycles in MEM_RD -> 8 cycles total; mem_read held through waits; reg_write=1, mem_to_reg=1 in WB_MEM.
REQ-042 beq with zero=1 then zero=0 -> pc_write=1 in BRANCH only for the first; both 3 cycles with pc_src=01.
REQ-043 opcode 0x3F, or opcode 0x00 with funct 0x25 -> ERR, err=01, no reg_write; stays until rst.
REQ-044 mem_ready held 0 in FETCH with run=1 -> ERR with err=10 after 8 wait cycles, ir_write never asserted.
REQ-045 rst asserted during MEM_WR wait -> state=FETCH, mem_write=0 asynchronously; run=0 afterwards -> FETCH held, mem_read=0.
